// File: rtl/mem_loader.sv
// mem_loader: receives a length-prefixed little-endian byte stream and writes it
// word by word into instruction memory. While the load is running the core is
// held in reset, and it is released once the load completes without error.
module mem_loader #(
    parameter int          MAX_WORDS = 1024,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_wr,
    output logic [63:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    localparam logic [31:0] MAX_WORDS_C = 32'(MAX_WORDS);

    state_t       state_r, state_s;
    logic [15:0]  len_r, len_s;
    logic [15:0]  word_idx_r, word_idx_s;
    logic [1:0]   byte_idx_r, byte_idx_s;
    logic [31:0]  word_r, word_s;
    logic [63:0]  addr_r, addr_s;
    logic         byte_ready_r, byte_ready_s;
    logic         mem_wr_r, mem_wr_s;
    logic         core_rst_r, core_rst_s;
    logic         done_r, done_s;
    logic         err_r, err_s;
    logic         hs_s;
    logic [31:0]  len_full_s;

    // Next-state, datapath and next-output computation for the load sequence.
    always_comb begin
        state_s    = state_r;
        len_s      = len_r;
        word_idx_s = word_idx_r;
        byte_idx_s = byte_idx_r;
        word_s     = word_r;
        addr_s     = addr_r;
        hs_s       = byte_valid & byte_ready_r;
        len_full_s = {16'h0000, byte_data, len_r[7:0]};

        case (state_r)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_s    = LEN0;
                    word_idx_s = 16'd0;
                    byte_idx_s = 2'd0;
                    word_s     = 32'd0;
                    addr_s     = BASE_ADDR;
                end else begin
                    state_s = state_r;
                end
            end
            LEN0: begin
                if (hs_s) begin
                    len_s[7:0] = byte_data;
                    state_s    = LEN1;
                end else begin
                    state_s = LEN0;
                end
            end
            LEN1: begin
                if (hs_s) begin
                    len_s[15:8] = byte_data;
                    if (len_full_s == 32'd0) begin
                        state_s = DONE;
                    end else if (len_full_s > MAX_WORDS_C) begin
                        state_s = ERR;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = LEN1;
                end
            end
            DATA: begin
                if (hs_s) begin
                    // Little-endian assembly: byte k of the group lands in [8k+7:8k].
                    case (byte_idx_r)
                        2'd0:    word_s[7:0]   = byte_data;
                        2'd1:    word_s[15:8]  = byte_data;
                        2'd2:    word_s[23:16] = byte_data;
                        2'd3:    word_s[31:24] = byte_data;
                        default: word_s        = word_r;
                    endcase
                    byte_idx_s = byte_idx_r + 2'd1;
                    if (byte_idx_r == 2'd3) begin
                        state_s = WRITE;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            WRITE: begin
                // Address advances after the write so it always tracks BASE_ADDR + 4*word_idx.
                word_idx_s = word_idx_r + 16'd1;
                addr_s     = addr_r + 64'd4;
                if (word_idx_s == len_r) begin
                    state_s = DONE;
                end else begin
                    state_s = DATA;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        byte_ready_s = (state_s == LEN0) || (state_s == LEN1) || (state_s == DATA);
        mem_wr_s     = (state_s == WRITE);
        core_rst_s   = (state_s != DONE);
        done_s       = (state_s == DONE);
        err_s        = (state_s == ERR);
    end

    // State, datapath and registered-output update with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            len_r        <= 16'd0;
            word_idx_r   <= 16'd0;
            byte_idx_r   <= 2'd0;
            word_r       <= 32'd0;
            addr_r       <= BASE_ADDR;
            byte_ready_r <= 1'b0;
            mem_wr_r     <= 1'b0;
            core_rst_r   <= 1'b1;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            len_r        <= len_s;
            word_idx_r   <= word_idx_s;
            byte_idx_r   <= byte_idx_s;
            word_r       <= word_s;
            addr_r       <= addr_s;
            byte_ready_r <= byte_ready_s;
            mem_wr_r     <= mem_wr_s;
            core_rst_r   <= core_rst_s;
            done_r       <= done_s;
            err_r        <= err_s;
        end
    end

    assign byte_ready = byte_ready_r;
    assign mem_wr     = mem_wr_r;
    assign mem_addr   = addr_r;
    assign mem_wdata  = word_r;
    assign core_rst   = core_rst_r;
    assign done       = done_r;
    assign err        = err_r;

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: stimulus pushes expected memory writes into a
// queue, and a monitor pops and compares them whenever mem_wr is seen.
module tb_mem_loader;

    localparam logic [63:0] BASE = 64'hFFFF_FFFF_FFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_wr;
    logic [63:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_rst;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [95:0] exp_q[$];

    mem_loader #(.MAX_WORDS(4), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_rst(core_rst),
        .done(done), .err(err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic expect_write(input logic [63:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Called at posedge+1; offers one byte and returns at posedge+1 after the handshake.
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (byte_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
        check("byte accepted", {63'd0, ok}, 64'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && done !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        check("done reached", {63'd0, done}, 64'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_wr === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected write: addr %h data %h expected none", mem_addr, mem_wdata);
                end else begin
                    logic [95:0] e;
                    e = exp_q.pop_front();
                    check("write addr", mem_addr, e[95:32]);
                    check("write data", {32'd0, mem_wdata}, {32'd0, e[31:0]});
                end
            end
        end
    end

    // Directed stimulus sequence.
    initial begin
        rst = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        #12;
        check("rst byte_ready", {63'd0, byte_ready}, 64'd0);
        check("rst mem_wr",     {63'd0, mem_wr},     64'd0);
        check("rst mem_addr",   mem_addr,            BASE);
        check("rst mem_wdata",  {32'd0, mem_wdata},  64'd0);
        check("rst core_rst",   {63'd0, core_rst},   64'd1);
        check("rst done_err",   {62'd0, done, err},  64'd0);
        #8 rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("idle core_rst", {63'd0, core_rst}, 64'd1);
            check("idle byte_ready", {63'd0, byte_ready}, 64'd0);
            @(posedge clk);
            #1;
        end

        // Two-word load.
        expect_write(BASE,          32'h0000_0013);
        expect_write(BASE + 64'd4,  32'h0010_0093);
        pulse_start();
        check("len0 byte_ready", {63'd0, byte_ready}, 64'd1);
        check("load core_rst", {63'd0, core_rst}, 64'd1);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        wait_done();
        check("t1 core_rst", {63'd0, core_rst}, 64'd0);
        check("t1 err", {63'd0, err}, 64'd0);
        check("t1 byte_ready", {63'd0, byte_ready}, 64'd0);
        check("t1 queue empty", 64'(exp_q.size()), 64'd0);

        // Restart from DONE, zero-length load.
        pulse_start();
        check("restart core_rst", {63'd0, core_rst}, 64'd1);
        check("restart done", {63'd0, done}, 64'd0);
        send_byte(8'h00); send_byte(8'h00);
        check("zero-len done", {63'd0, done}, 64'd1);
        check("zero-len core_rst", {63'd0, core_rst}, 64'd0);

        // Length above capacity.
        pulse_start();
        send_byte(8'h05); send_byte(8'h00);
        check("ovf err", {63'd0, err}, 64'd1);
        check("ovf core_rst", {63'd0, core_rst}, 64'd1);
        check("ovf byte_ready", {63'd0, byte_ready}, 64'd0);
        check("ovf done", {63'd0, done}, 64'd0);
        idle_cycles(4);
        check("ovf err held", {63'd0, err}, 64'd1);

        // Full-capacity load with address wrap and a mid-word valid gap.
        expect_write(BASE,          32'h4433_2211);
        expect_write(BASE + 64'd4,  32'h8877_6655);
        expect_write(64'd0,         32'h0403_0201);
        expect_write(64'd4,         32'hD3C2_B1A0);
        pulse_start();
        check("from err cleared", {63'd0, err}, 64'd0);
        send_byte(8'h04); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("gap byte_ready", {63'd0, byte_ready}, 64'd1);
            @(posedge clk);
            #1;
        end
        send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'hA0); send_byte(8'hB1); send_byte(8'hC2); send_byte(8'hD3);
        wait_done();
        check("t4 queue empty", 64'(exp_q.size()), 64'd0);

        // Reset during the third data byte, then a clean one-word load.
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB);
        byte_valid = 1'b1;
        byte_data  = 8'hCC;
        #2 rst = 1'b0;
        #1;
        check("abort byte_ready", {63'd0, byte_ready}, 64'd0);
        check("abort mem_wr", {63'd0, mem_wr}, 64'd0);
        check("abort mem_addr", mem_addr, BASE);
        check("abort mem_wdata", {32'd0, mem_wdata}, 64'd0);
        check("abort core_rst", {63'd0, core_rst}, 64'd1);
        byte_valid = 1'b0;
        #1 rst = 1'b1;
        idle_cycles(3);
        check("post-abort idle", {62'd0, byte_ready, core_rst}, 64'd1);
        expect_write(BASE, 32'hDDCC_BBAA);
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        wait_done();
        check("t5 queue empty", 64'(exp_q.size()), 64'd0);

        // Start pulse during DATA is ignored.
        expect_write(BASE, 32'h4030_2010);
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h10); send_byte(8'h20);
        pulse_start();
        check("mid start byte_ready", {63'd0, byte_ready}, 64'd1);
        send_byte(8'h30); send_byte(8'h40);
        wait_done();
        check("t6 queue empty", 64'(exp_q.size()), 64'd0);
        pulse_start();
        check("start in done core_rst", {63'd0, core_rst}, 64'd1);
        send_byte(8'h00); send_byte(8'h00);
        check("final done", {63'd0, done}, 64'd1);
        idle_cycles(2);
        check("final queue empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
